cic_decim_prog: RTL

- Parametrised CIC sinc^N decimator; successor to the fixed third-order, D=256 sigma-delta filter.
- Filters the 1-bit sigma-delta modulator bitstream to a full-precision multi-bit word.
- Decimation ratio is programmable at run time; decimation timing is generated internally.
- Entirely single clock domain: no external divided clock, no negedge logic. Comb section advances on a clock-enable tick, and output words carry a valid strobe and a settled flag.

---
 rtl/cic_decim_prog.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cic_decim_prog.sv
// Programmable-ratio CIC sinc^ORDER decimator for a 1-bit sigma-delta bitstream.
// Optional register monitor port is compiled in with `define CIC_MONITOR_EN.
module cic_decim_prog #(
  parameter int ORDER          = 3,
  parameter int MAX_DECIMATION = 256,
  parameter int CNT_W          = $clog2(MAX_DECIMATION),
  parameter int ACC_W          = ORDER*CNT_W+1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             in,
  input  logic [CNT_W-1:0] dec_ratio_m1,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  output logic             settled
`ifdef CIC_MONITOR_EN
  ,
  input  logic [3:0]       mon_sel,
  output logic [ACC_W-1:0] mon_out
`endif
);

  localparam int              SC_W     = $clog2(ORDER + 2);
  localparam logic [SC_W-1:0] SETTLE_N = SC_W'(ORDER + 1);

  logic [ACC_W-1:0] r_acc [ORDER];
  logic [ACC_W-1:0] r_dly [ORDER];
  logic [ACC_W-1:0] w_comb [ORDER];
  logic [ACC_W-1:0] w_diff;
  logic [ACC_W-1:0] w_in_coded;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ratio;
  logic [CNT_W-1:0] w_ratio_new;
  logic [SC_W-1:0]  r_strb;
  logic             w_tick;

  // A requested ratio of zero would mean D=1, which the comb cannot use.
  function automatic logic [CNT_W-1:0] eff_ratio(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    return (v >= SETTLE_N) ? v : v + SC_W'(1);
  endfunction

  assign w_in_coded  = {{(ACC_W-1){1'b0}}, in};
  assign w_tick      = enable && (r_cnt == r_ratio);
  assign w_ratio_new = eff_ratio(dec_ratio_m1);

  // Stage p0: integrators, full rate, wrapping modulo 2^ACC_W
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < ORDER; k++) r_acc[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < ORDER; k++) r_acc[k] <= '0;
    end else if (enable) begin
      r_acc[0] <= r_acc[0] + w_in_coded;
      for (int k = 1; k < ORDER; k++) r_acc[k] <= r_acc[k] + r_acc[k-1];
    end
  end

  // Decimation timing; the ratio only changes at a period boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_ratio <= '1;
    end else if (clear) begin
      r_cnt   <= '0;
      r_ratio <= w_ratio_new;
    end else if (w_tick) begin
      r_cnt   <= '0;
      r_ratio <= w_ratio_new;
    end else if (enable) begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Stage p1: comb chain on the pre-update last integrator value
  always_comb begin
    w_diff = r_acc[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      w_diff    = w_diff - r_dly[k];
      w_comb[k] = w_diff;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < ORDER; k++) r_dly[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < ORDER; k++) r_dly[k] <= '0;
    end else if (w_tick) begin
      r_dly[0] <= r_acc[ORDER-1];
      for (int k = 1; k < ORDER; k++) r_dly[k] <= w_comb[k-1];
    end
  end

  // Stage p2: output word, strobe and settle tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      settled   <= 1'b0;
      r_strb    <= '0;
    end else if (clear) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      settled   <= 1'b0;
      r_strb    <= '0;
    end else begin
      out_valid <= w_tick;
      if (w_tick) begin
        out_data <= w_comb[ORDER-1];
        if (w_ratio_new != r_ratio) begin
          r_strb  <= '0;
          settled <= 1'b0;
        end else begin
          r_strb  <= sat_inc(r_strb);
          settled <= (sat_inc(r_strb) == SETTLE_N);
        end
      end
    end
  end

`ifdef CIC_MONITOR_EN
  logic [ACC_W-1:0] w_mon;

  always_comb begin
    w_mon = '0;
    for (int k = 0; k < ORDER; k++) begin
      if (mon_sel == 4'(k))     w_mon = r_acc[k];
      if (mon_sel == 4'(k + 5)) w_mon = r_dly[k];
    end
    if (mon_sel == 4'd13) w_mon = {{(ACC_W-CNT_W){1'b0}}, r_cnt};
    if (mon_sel == 4'd14) w_mon = {{(ACC_W-2){1'b0}}, settled, out_valid};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mon_out <= '0;
    else          mon_out <= w_mon;
  end
`endif

endmodule
